// File: rtl/can_tx_pkg.sv
// ---------------------------------------------------------------------------
// can_tx_pkg
// Shared constants and helpers for the CAN transmit path.
//   CAN_MSG_W      : width of one assembled frame entry (128 bits)
//   ADDR_*         : software word-address codes for the four frame words
//   *_LSB / WORD_W : bit position of each 32-bit word inside an entry
//   can_msg_t      : packed view of an entry {id, dlc, dw1, dw2}
//   stage_word()   : returns a staging value with one word replaced
// ---------------------------------------------------------------------------
package can_tx_pkg;

  localparam int CAN_MSG_W = 128;
  localparam int WORD_W    = 32;

  localparam logic [1:0] ADDR_ID  = 2'd0;
  localparam logic [1:0] ADDR_DLC = 2'd1;
  localparam logic [1:0] ADDR_DW1 = 2'd2;
  localparam logic [1:0] ADDR_DW2 = 2'd3;

  localparam int ID_LSB  = 96;
  localparam int DLC_LSB = 64;
  localparam int DW1_LSB = 32;
  localparam int DW2_LSB = 0;

  typedef struct packed {
    logic [WORD_W-1:0] id;
    logic [WORD_W-1:0] dlc;
    logic [WORD_W-1:0] dw1;
    logic [WORD_W-1:0] dw2;
  } can_msg_t;

  // Replace the word selected by addr. DW2 is never staged (it commits the
  // frame directly), so that address leaves the staging value untouched.
  function automatic logic [CAN_MSG_W-1:0] stage_word(
    input logic [CAN_MSG_W-1:0] stage,
    input logic [1:0]           addr,
    input logic [WORD_W-1:0]    data
  );
    logic [CAN_MSG_W-1:0] r;
    r = stage;
    case (addr)
      ADDR_ID:  r[ID_LSB  +: WORD_W] = data;
      ADDR_DLC: r[DLC_LSB +: WORD_W] = data;
      ADDR_DW1: r[DW1_LSB +: WORD_W] = data;
      default:  r = stage;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/can_sync_fifo_mem.sv
// ---------------------------------------------------------------------------
// can_sync_fifo_mem
// DEPTH x W storage for CAN frame FIFOs: synchronous write, asynchronous
// read so the head entry can be presented show-ahead.
//   clk_i   : clock, write on rising edge
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational from raddr_i)
// ---------------------------------------------------------------------------
module can_sync_fifo_mem
  import can_tx_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = CAN_MSG_W
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tx_fifo.sv
// ---------------------------------------------------------------------------
// tx_fifo
// Transmit message FIFO. Software writes a CAN frame as four 32-bit words;
// ID/DLC/DW1 go to a staging register, the DW2 write commits the assembled
// 128-bit entry. The oldest entry is shown on txfifo_op and is popped when
// the transmitter reports the frame sent.
//   sys_clk   : clock
//   sys_rst_n : synchronous active-low reset
//   wr_en     : word-write strobe
//   wr_addr   : word select 0=ID 1=DLC 2=DW1 3=DW2 (commit)
//   wr_data   : word data
//   pop       : transmit-complete pulse
//   ovr_clr   : clear sticky overflow
//   wm_wr     : load almost-empty watermark
//   wm_data   : watermark value
//   txfifo_op : head entry {ID, DLC, DW1, DW2}, zero when empty
//   TXFEMP    : empty
//   TXFLL     : full
//   TXFWMEMP  : count <= watermark
//   TXFOVR    : sticky overflow (a commit was dropped)
//   fifo_cnt  : occupied entries 0..DEPTH
// ---------------------------------------------------------------------------
module tx_fifo
  import can_tx_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int AW         = 4,
  parameter int WM_DEFAULT = 3
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 wr_en,
  input  logic [1:0]           wr_addr,
  input  logic [WORD_W-1:0]    wr_data,
  input  logic                 pop,
  input  logic                 ovr_clr,
  input  logic                 wm_wr,
  input  logic [AW-1:0]        wm_data,
  output logic [CAN_MSG_W-1:0] txfifo_op,
  output logic                 TXFEMP,
  output logic                 TXFLL,
  output logic                 TXFWMEMP,
  output logic                 TXFOVR,
  output logic [AW:0]          fifo_cnt
);

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] WM_RST   = AW'(WM_DEFAULT);

  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]          cnt_q, cnt_d;
  logic [CAN_MSG_W-1:0] stage_q, stage_d;
  logic                 ovr_q, ovr_d;
  logic [AW-1:0]        wm_q, wm_d;

  logic     commit_req;
  logic     commit_ok;
  logic     pop_ok;
  logic     drop;
  logic     is_full;
  logic     is_empty;
  can_msg_t commit_msg;
  logic [CAN_MSG_W-1:0] head_data;

  assign is_full  = (cnt_q == CNT_FULL);
  assign is_empty = (cnt_q == '0);

  assign commit_req = wr_en && (wr_addr == ADDR_DW2);
  assign pop_ok     = pop && !is_empty;
  // A pop in the same cycle frees the slot the commit needs, so a full FIFO
  // still accepts the frame when the transmitter retires the head.
  assign commit_ok  = commit_req && (!is_full || pop_ok);
  assign drop       = commit_req && is_full && !pop_ok;

  // Final word comes straight from the bus; the rest from staging.
  always_comb begin
    commit_msg     = stage_q;
    commit_msg.dw2 = wr_data;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    stage_d  = stage_q;
    ovr_d    = ovr_q;
    wm_d     = wm_q;

    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (commit_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    case ({commit_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    // Staging is kept after commit so repeated frames can rewrite only
    // the words that changed.
    if (wr_en) begin
      stage_d = stage_word(stage_q, wr_addr, wr_data);
    end

    // Setting beats clearing when both happen together.
    if (drop) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end

    if (wm_wr) begin
      wm_d = wm_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      stage_q  <= '0;
      ovr_q    <= 1'b0;
      wm_q     <= WM_RST;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      stage_q  <= stage_d;
      ovr_q    <= ovr_d;
      wm_q     <= wm_d;
    end
  end

  // Write enable is gated by reset so a commit during reset is lost too.
  can_sync_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (CAN_MSG_W)
  ) u_mem (
    .clk_i   (sys_clk),
    .we_i    (commit_ok && sys_rst_n),
    .waddr_i (wr_ptr_q),
    .wdata_i (commit_msg),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_data)
  );

  assign txfifo_op = is_empty ? '0 : head_data;
  assign TXFEMP    = is_empty;
  assign TXFLL     = is_full;
  assign TXFWMEMP  = (cnt_q <= {1'b0, wm_q});
  assign TXFOVR    = ovr_q;
  assign fifo_cnt  = cnt_q;

endmodule

// File: tb/tb_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_tx_fifo
// Self-checking bench for tx_fifo. A queue-based model tracks the expected
// FIFO contents, staging words, overflow flag and watermark; a compare
// process checks every DUT output against it on each falling edge. Directed
// scenarios add literal expectations at key points.
// ---------------------------------------------------------------------------
module tb_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic          wr_en;
  logic [1:0]    wr_addr;
  logic [31:0]   wr_data;
  logic          pop;
  logic          ovr_clr;
  logic          wm_wr;
  logic [AW-1:0] wm_data;
  logic [127:0]  txfifo_op;
  logic          TXFEMP;
  logic          TXFLL;
  logic          TXFWMEMP;
  logic          TXFOVR;
  logic [AW:0]   fifo_cnt;

  tx_fifo #(.DEPTH(DEPTH), .AW(AW), .WM_DEFAULT(3)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .pop       (pop),
    .ovr_clr   (ovr_clr),
    .wm_wr     (wm_wr),
    .wm_data   (wm_data),
    .txfifo_op (txfifo_op),
    .TXFEMP    (TXFEMP),
    .TXFLL     (TXFLL),
    .TXFWMEMP  (TXFWMEMP),
    .TXFOVR    (TXFOVR),
    .fifo_cnt  (fifo_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [127:0] m_q[$];
  logic [31:0]  m_id, m_dlc, m_dw1;
  logic         m_ovr;
  int           m_wm;
  bit           m_valid = 0;

  initial begin
    forever begin
      @(posedge sys_clk);
      if (!sys_rst_n) begin
        m_q.delete();
        m_id = 0; m_dlc = 0; m_dw1 = 0;
        m_ovr = 0;
        m_wm = 3;
        m_valid = 1;
      end else if (m_valid) begin
        bit do_commit, do_pop, was_full;
        do_commit = wr_en && (wr_addr == 2'd3);
        do_pop    = pop && (m_q.size() > 0);
        was_full  = (m_q.size() == DEPTH);
        if (do_commit && was_full && !pop) m_ovr = 1;
        else if (ovr_clr) m_ovr = 0;
        if (do_pop) void'(m_q.pop_front());
        if (do_commit && (!was_full || do_pop))
          m_q.push_back({m_id, m_dlc, m_dw1, wr_data});
        if (wr_en && wr_addr == 2'd0) m_id  = wr_data;
        if (wr_en && wr_addr == 2'd1) m_dlc = wr_data;
        if (wr_en && wr_addr == 2'd2) m_dw1 = wr_data;
        if (wm_wr) m_wm = int'(wm_data);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge sys_clk);
      if (m_valid) begin
        int n;
        n = m_q.size();
        chk("cyc_cnt",   128'(fifo_cnt), 128'(n));
        chk("cyc_op",    txfifo_op, (n > 0) ? m_q[0] : 128'h0);
        chk("cyc_emp",   128'(TXFEMP),   128'(n == 0));
        chk("cyc_fll",   128'(TXFLL),    128'(n == DEPTH));
        chk("cyc_wmemp", 128'(TXFWMEMP), 128'(n <= m_wm));
        chk("cyc_ovr",   128'(TXFOVR),   128'(m_ovr));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic write_word(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 0;
  endtask

  task automatic send_frame(input logic [31:0] id, input logic [31:0] dlc,
                            input logic [31:0] dw1, input logic [31:0] dw2);
    write_word(2'd0, id);
    write_word(2'd1, dlc);
    write_word(2'd2, dw1);
    write_word(2'd3, dw2);
    $display("frame commit id=%h cnt=%0d", id, fifo_cnt);
  endtask

  task automatic do_pop();
    pop = 1;
    tick();
    pop = 0;
    $display("pop cnt=%0d", fifo_cnt);
  endtask

  initial begin
    sys_rst_n = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    pop = 0; ovr_clr = 0; wm_wr = 0; wm_data = 0;
    tick(); tick();
    sys_rst_n = 1;
    tick();

    // Reset state
    chk("rst_emp",   128'(TXFEMP), 128'd1);
    chk("rst_fll",   128'(TXFLL), 128'd0);
    chk("rst_wmemp", 128'(TXFWMEMP), 128'd1);
    chk("rst_cnt",   128'(fifo_cnt), 128'd0);
    chk("rst_op",    txfifo_op, 128'h0);

    // Single frame assembly
    send_frame(32'h12340000, 32'h80000000, 32'hAABBCCDD, 32'h11223344);
    chk("f1_op",  txfifo_op, 128'h12340000_80000000_AABBCCDD_11223344);
    chk("f1_cnt", 128'(fifo_cnt), 128'd1);
    chk("f1_emp", 128'(TXFEMP), 128'd0);
    do_pop();
    chk("f1_popped", 128'(TXFEMP), 128'd1);

    // Fill to full, only ID and DW2 rewritten per frame
    for (int k = 0; k < DEPTH; k++) begin
      write_word(2'd0, 32'h100 + k);
      write_word(2'd3, 32'h5000 + k);
      $display("fill commit k=%0d cnt=%0d", k, fifo_cnt);
    end
    chk("full_fll", 128'(TXFLL), 128'd1);
    chk("full_op",  txfifo_op, 128'h00000100_80000000_AABBCCDD_00005000);
    write_word(2'd3, 32'hDEAD);
    $display("overflow commit cnt=%0d ovr=%0b", fifo_cnt, TXFOVR);
    chk("ovf_flag", 128'(TXFOVR), 128'd1);
    chk("ovf_cnt",  128'(fifo_cnt), 128'd16);
    ovr_clr = 1; tick(); ovr_clr = 0;
    chk("ovr_clr", 128'(TXFOVR), 128'd0);

    // Full: commit and pop together
    write_word(2'd0, 32'h1FF);
    wr_en = 1; wr_addr = 2'd3; wr_data = 32'h5FFF; pop = 1;
    tick();
    wr_en = 0; pop = 0;
    $display("commit+pop on full cnt=%0d", fifo_cnt);
    chk("cp_cnt",  128'(fifo_cnt), 128'd16);
    chk("cp_ovr",  128'(TXFOVR), 128'd0);
    chk("cp_head", 128'(txfifo_op[127:96]), 128'h101);
    for (int k = 0; k < DEPTH - 1; k++) do_pop();
    chk("cp_tail", txfifo_op, 128'h000001FF_80000000_AABBCCDD_00005FFF);
    do_pop();

    // 40 frames, order across wrap, watermark edge
    wm_wr = 1; wm_data = 4'd3; tick(); wm_wr = 0;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 10; k++) begin
        write_word(2'd0, 32'h200 + r * 10 + k);
        write_word(2'd3, 32'h600 + r * 10 + k);
      end
      for (int k = 0; k < 10; k++) begin
        chk("order_id", 128'(txfifo_op[127:96]), 128'(32'h200 + r * 10 + k));
        if (fifo_cnt == 4) chk("wm_at4", 128'(TXFWMEMP), 128'd0);
        if (fifo_cnt == 3) chk("wm_at3", 128'(TXFWMEMP), 128'd1);
        do_pop();
      end
    end
    wm_wr = 1; wm_data = 4'd0; tick(); wm_wr = 0;
    chk("wm0_empty", 128'(TXFWMEMP), 128'd1);
    send_frame(32'h7, 32'h8, 32'h9, 32'hA);
    chk("wm0_one", 128'(TXFWMEMP), 128'd0);
    do_pop();

    // Reset mid-assembly discards staged words
    write_word(2'd0, 32'hCAFE0000);
    write_word(2'd1, 32'h40000000);
    sys_rst_n = 0; tick(); sys_rst_n = 1;
    write_word(2'd3, 32'h99887766);
    $display("commit after reset cnt=%0d", fifo_cnt);
    chk("rst_stage_op", txfifo_op, 128'h00000000_00000000_00000000_99887766);
    do_pop();
    do_pop();
    chk("pop_empty_cnt", 128'(fifo_cnt), 128'd0);
    chk("pop_empty_ovr", 128'(TXFOVR), 128'd0);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_fifo.md
Name: tx_fifo

Overview:
- Transmit message FIFO feeding the TX priority stage. Software writes one CAN frame as four 32-bit words (ID, DLC, DW1, DW2), and the block assembles them into a 128-bit entry.
- The oldest entry is presented show-ahead on txfifo_op, and is popped when the transmitter reports that frame sent.
- Provides the full/empty/overflow status (TXFLL, TXFEMP, TXFOVR) used by the register block and interrupt logic.

Parameters:
- DEPTH, 16, number of 128-bit entries; power of two, 2..64.
- AW, 4, pointer width = log2(DEPTH).
- WM_DEFAULT, 3, reset value of the almost-empty watermark.

Ports:
- sys_clk  input  1  system clock, all logic on rising edge.
- sys_rst_n  input  1  synchronous active-low reset.
- wr_en  input  1  one-cycle word-write strobe.
- wr_addr  input  2  word select: 0=ID, 1=DLC, 2=DW1, 3=DW2 (commit).
- wr_data  input  32  word data.
- pop  input  1  transmit-complete pulse from the FIFO-sourced frame.
- ovr_clr  input  1  clears the sticky overflow flag.
- wm_wr  input  1  load watermark.
- wm_data  input  AW  watermark value.
- txfifo_op  output  128  head entry: [127:96]=ID, [95:64]=DLC, [63:32]=DW1, [31:0]=DW2.
- TXFEMP  output  1  FIFO empty.
- TXFLL  output  1  FIFO full.
- TXFWMEMP  output  1  count <= watermark.
- TXFOVR  output  1  sticky overflow flag.
- fifo_cnt  output  AW+1  occupied entries, 0..DEPTH.

Behaviour:
- Reset (sys_rst_n=0 at a clock edge): rd_ptr, wr_ptr, count=0; staging register=0; TXFOVR=0; watermark=WM_DEFAULT.
  - After reset: TXFEMP=1, TXFLL=0, TXFWMEMP=1, fifo_cnt=0, txfifo_op=0.
  - Reset mid-assembly discards any partial frame. Reset overrides every other input.
- Staging:
  - wr_en with wr_addr 0..2 writes the corresponding 32-bit slice of the 128-bit staging register. Rewrites overwrite; there is no ordering check.
- Commit:
  - wr_en with wr_addr=3 forms {stage[127:32], wr_data} and writes it to mem[wr_ptr]. wr_ptr increments mod DEPTH and count increments, both visible the next cycle.
  - The staging register is not cleared after commit, so repeated frames may rewrite only the changed words.
- Commit when full:
  - If count==DEPTH and pop is not asserted the same cycle, the frame is dropped. Pointers and count are unchanged, and TXFOVR is set the next cycle.
  - If pop is asserted in that same cycle, the commit is accepted and count stays DEPTH.
- Pop:
  - pop with count>0 increments rd_ptr mod DEPTH and decrements count.
  - pop when empty is ignored: no pointer change, no flag.
- Simultaneous commit and pop with 0<count<DEPTH: both pointers advance and count is unchanged.
- Simultaneous commit and pop with count==0: the pop is ignored, the commit is accepted, and count becomes 1.
- txfifo_op is combinational from mem[rd_ptr], forced to 0 when count==0.
  - A committed frame appears on txfifo_op the cycle after the commit edge.
  - After a pop, the next entry appears the cycle after the pop edge.
  - Write-to-head latency is 1 cycle; the downstream stage registers this again.
- Flags are combinational from registered count: TXFEMP=(count==0), TXFLL=(count==DEPTH), TXFWMEMP=(count<=watermark).
- TXFOVR:
  - Set on a dropped commit; cleared by ovr_clr.
  - If set and ovr_clr occur in the same cycle, set wins.
- wm_wr loads the watermark, which takes effect the next cycle.
- Pointer wrap: AW-bit pointers wrap naturally. Full/empty are determined from count, never from pointer equality.

Decomposition:
- Package can_tx_pkg: CAN_MSG_W=128; word-address constants ADDR_ID=0, ADDR_DLC=1, ADDR_DW1=2, ADDR_DW2=3; slice-position constants for ID/DLC/DW1/DW2.
- Sub-module can_sync_fifo_mem: DEPTH x 128 memory with synchronous write and asynchronous read. The same sub-module is reused for the TX high-priority buffer.

Test Plan:
- Reset then idle -> TXFEMP=1, TXFLL=0, TXFWMEMP=1, fifo_cnt=0, txfifo_op=0.
- Write ID=0x12340000, DLC=0x80000000, DW1=0xAABBCCDD, DW2=0x11223344 -> next cycle txfifo_op=0x12340000_80000000_AABBCCDD_11223344, fifo_cnt=1, TXFEMP=0.
- Commit 16 frames -> TXFLL=1; 17th commit -> dropped, TXFOVR=1, fifo_cnt=16; ovr_clr -> TXFOVR=0.
- Full FIFO, commit and pop in the same cycle -> fifo_cnt stays 16, TXFOVR=0; head advances to frame 2, and the new frame is stored at the tail.
- Fill/drain 40 frames with incrementing IDs, watermark=3 -> FIFO order preserved across pointer wrap; TXFWMEMP toggles exactly at count 4->3.
- Stage ID+DLC, assert sys_rst_n=0 for 1 cycle, then write DW2 only -> committed frame has ID=0, DLC=0; pop on empty FIFO -> no change.
